// File: rtl/mul_limb_seq_pkg.sv
// Shared types for the limb-multiplier operand sequencer: FSM states, pipeline tag, issue count.
package mul_limb_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Wide enough for offsets up to 2*NUM_LIMBS-2 with NUM_LIMBS <= 128.
  localparam int OFFS_W = 8;

  typedef struct packed {
    logic              valid;
    logic [OFFS_W-1:0] offset;
    logic              dbl;
  } tag_t;

  function automatic int issue_count(input int num_limbs, input logic sqr);
    return sqr ? (num_limbs * (num_limbs + 1)) / 2 : num_limbs * num_limbs;
  endfunction

endpackage

// File: rtl/mul_limb_seq_if.sv
// Operand, multiplier and result signals of mul_limb_seq; slave is the sequencer side.
// MUL_LIMB_SEQ_SQR_EN adds in_sqr.
interface mul_limb_seq_if #(
  parameter int LIMB_BITS = 17,
  parameter int NUM_LIMBS = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_LIMBS*LIMB_BITS-1:0]   in_a;
  logic [NUM_LIMBS*LIMB_BITS-1:0]   in_b;
`ifdef MUL_LIMB_SEQ_SQR_EN
  logic                             in_sqr;
`endif
  logic [LIMB_BITS-1:0]             mul_a;
  logic [LIMB_BITS-1:0]             mul_b;
  logic [2*LIMB_BITS-1:0]           mul_c;
  logic                             out_valid;
  logic                             out_ready;
  logic [2*NUM_LIMBS*LIMB_BITS-1:0] out_c;

`ifdef MUL_LIMB_SEQ_SQR_EN
  modport master (
    output in_valid, in_a, in_b, in_sqr, mul_c, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_c
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sqr, mul_c, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_c
  );
`else
  modport master (
    output in_valid, in_a, in_b, mul_c, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_c
  );
  modport slave (
    input  in_valid, in_a, in_b, mul_c, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_c
  );
`endif

endinterface

// File: rtl/mul_limb_acc.sv
// Full-width product accumulator: acc += product << (offset*LIMB_BITS + dbl), one update per cycle.
// Clear has priority over accumulate; no overflow is possible at 2*NUM_LIMBS*LIMB_BITS.
module mul_limb_acc
  import mul_limb_seq_pkg::*;
#(
  parameter int LIMB_BITS = 17,
  parameter int NUM_LIMBS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_clr,
  input  logic                             i_en,
  input  logic [OFFS_W-1:0]                i_offset,
  input  logic                             i_dbl,
  input  logic [2*LIMB_BITS-1:0]           i_product,
  output logic [2*NUM_LIMBS*LIMB_BITS-1:0] o_acc
);

  localparam int ACC_W = 2 * NUM_LIMBS * LIMB_BITS;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_term;

  always_comb begin
    w_term = ACC_W'(i_product) << (int'(i_offset) * LIMB_BITS + int'(i_dbl));
  end

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mul_limb_seq.sv
// Multi-precision sequencer around a MUL_LAT-cycle limb multiplier; result N^2+MUL_LAT+1 cycles after accept.
// One job at a time over valid/ready; `MUL_LIMB_SEQ_SQR_EN adds in_sqr (A*A, N(N+1)/2 issues).
module mul_limb_seq
  import mul_limb_seq_pkg::*;
#(
  parameter int LIMB_BITS = 17,
  parameter int NUM_LIMBS = 4,
  parameter int MUL_LAT   = 2
) (
  input logic           clk,
  input logic           reset,
  mul_limb_seq_if.slave bus
);

  localparam int IW       = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam int CW       = $clog2(NUM_LIMBS * NUM_LIMBS + 1);
  localparam int CNT_BASE = issue_count(NUM_LIMBS, 1'b0);
  localparam int CNT_SQR  = issue_count(NUM_LIMBS, 1'b1);
  localparam logic [IW-1:0] LAST = IW'(NUM_LIMBS - 1);

  state_t                              r_state, w_state_nxt;
  logic [IW-1:0]                       r_i, r_j, w_i_nxt, w_j_nxt;
  logic [CW-1:0]                       r_cnt, w_cnt_nxt;
  logic [NUM_LIMBS-1:0][LIMB_BITS-1:0] r_a, r_b;
  tag_t                                r_tags [MUL_LAT];
  tag_t                                w_push;
  logic                                w_accept;
  logic                                w_pending;
  logic                                w_last;
  logic                                w_sqr;
  logic [2*NUM_LIMBS*LIMB_BITS-1:0]    w_acc;

`ifdef MUL_LIMB_SEQ_SQR_EN
  logic r_sqr;
  assign w_sqr = r_sqr;
`else
  assign w_sqr = 1'b0;
`endif

  assign w_last = (r_cnt == (w_sqr ? CW'(CNT_SQR - 1) : CW'(CNT_BASE - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_cnt_nxt   = r_cnt;
    w_push      = '0;
    w_accept    = 1'b0;
    bus.mul_a   = '0;
    bus.mul_b   = '0;
    // Tags still short of the retire slot keep DRAIN going.
    w_pending   = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      w_pending = w_pending | r_tags[k].valid;
    end

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mul_a     = r_a[r_i];
        bus.mul_b     = w_sqr ? r_a[r_j] : r_b[r_j];
        w_push.valid  = 1'b1;
        w_push.offset = OFFS_W'(r_i) + OFFS_W'(r_j);
        w_push.dbl    = w_sqr && (r_i != r_j);
        w_cnt_nxt     = r_cnt + CW'(1);
        if (r_j == LAST) begin
          // Squaring only visits the upper triangle, so j restarts at the new i.
          w_j_nxt = w_sqr ? r_i + IW'(1) : '0;
          w_i_nxt = r_i + IW'(1);
        end else begin
          w_j_nxt = r_j + IW'(1);
        end
        if (w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_pending) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
`ifdef MUL_LIMB_SEQ_SQR_EN
      r_sqr <= 1'b0;
`endif
      for (int k = 0; k < MUL_LAT; k++) begin
        r_tags[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
`ifdef MUL_LIMB_SEQ_SQR_EN
        r_sqr <= bus.in_sqr;
`endif
      end
      r_tags[0] <= w_push;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_tags[k] <= r_tags[k-1];
      end
    end
  end

  mul_limb_acc #(
    .LIMB_BITS (LIMB_BITS),
    .NUM_LIMBS (NUM_LIMBS)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_en      (r_tags[MUL_LAT-1].valid),
    .i_offset  (r_tags[MUL_LAT-1].offset),
    .i_dbl     (r_tags[MUL_LAT-1].dbl),
    .i_product (bus.mul_c),
    .o_acc     (w_acc)
  );

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_c     = (r_state == DONE) ? w_acc : '0;

endmodule
